// File: rtl/key_speed_ctrl_if.sv
// Key/speed control bus: raw pushbuttons in, speed code, display enable and press strobes out.
// The controller takes the slave modport; the driver of the keys takes the master modport.
interface key_speed_ctrl_if;
   logic [2:0] KEY;
   logic [3:0] divide;
   logic       enable;
   logic [2:0] key_pulse;

   modport master (output KEY, input divide, input enable, input key_pulse);
   modport slave  (input KEY, output divide, output enable, output key_pulse);
endinterface

// File: rtl/key_speed_ctrl.sv
// Pushbutton speed controller: synchronize, debounce, strobe on press, saturating divide and enable toggle.
// Optional auto-repeat on keys 0/1 is built only when KEY_SPEED_AUTOREPEAT_EN is defined.
module key_speed_ctrl #(
   parameter int         DEBOUNCE_CYCLES = 500000,
   parameter logic [3:0] DIVIDE_INIT     = 4'd8,
   parameter int         REPEAT_CYCLES   = 12500000
) (
   input logic              clkIn,
   input logic              rst,
   key_speed_ctrl_if.slave  bus
);

   localparam int DCW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DCW-1:0] DEB_LAST = DCW'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20)) begin : g_bad_debounce
      $error("key_speed_ctrl: DEBOUNCE_CYCLES out of range");
   end
   if (REPEAT_CYCLES < 2) begin : g_bad_repeat
      $error("key_speed_ctrl: REPEAT_CYCLES must be at least 2");
   end

   logic [2:0]     r_sync1;
   logic [2:0]     r_sync2;
   logic [2:0]     r_deb;
   logic [2:0]     r_deb_d;
   logic [2:0]     r_pulse;
   logic [DCW-1:0] r_cnt [3];
   logic [3:0]     r_divide;
   logic           r_enable;
   logic [2:0]     w_rep_pulse;

   // Synchronizer stores pressed-polarity so its reset value means "nothing pressed".
   always_ff @(posedge clkIn) begin
      if (rst) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_deb    <= '0;
         r_deb_d  <= '0;
         r_pulse  <= '0;
         r_divide <= DIVIDE_INIT;
         r_enable <= 1'b1;
         for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
      end else begin
         r_sync1 <= ~bus.KEY;
         r_sync2 <= r_sync1;
         for (int i = 0; i < 3; i++) begin
            if (r_sync2[i] == r_deb[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == DEB_LAST) begin
               r_cnt[i] <= '0;
               r_deb[i] <= ~r_deb[i];
            end else begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end
         r_deb_d <= r_deb;
         r_pulse <= (r_deb & ~r_deb_d) | w_rep_pulse;

         // Opposing strobes in the same cycle cancel out.
         case (r_pulse[1:0])
            2'b01:   if (r_divide != 4'hF) r_divide <= r_divide + 4'd1;
            2'b10:   if (r_divide != 4'h0) r_divide <= r_divide - 4'd1;
            default: r_divide <= r_divide;
         endcase
         if (r_pulse[2]) r_enable <= ~r_enable;
      end
   end

`ifdef KEY_SPEED_AUTOREPEAT_EN
   localparam int RCW = $clog2(REPEAT_CYCLES);
   localparam logic [RCW-1:0] REP_LAST = RCW'(REPEAT_CYCLES - 1);

   logic [RCW-1:0] r_rep_cnt [2];
   logic [1:0]     w_held;
   logic [1:0]     w_rep_hit;

   // Counting starts the cycle after the press strobe so repeats land every REPEAT_CYCLES after it.
   always_comb begin
      w_held      = r_deb[1:0] & r_deb_d[1:0];
      w_rep_hit   = '0;
      for (int i = 0; i < 2; i++) w_rep_hit[i] = w_held[i] && (r_rep_cnt[i] == REP_LAST);
      w_rep_pulse = {1'b0, w_rep_hit};
   end

   always_ff @(posedge clkIn) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) r_rep_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (!w_held[i] || w_rep_hit[i]) r_rep_cnt[i] <= '0;
            else                            r_rep_cnt[i] <= r_rep_cnt[i] + 1'b1;
         end
      end
   end
`else
   always_comb w_rep_pulse = '0;
`endif

   assign bus.divide    = r_divide;
   assign bus.enable    = r_enable;
   assign bus.key_pulse = r_pulse;

endmodule

// File: tb/tb_key_speed_ctrl.sv
// Scoreboard bench for key_speed_ctrl: each press pushes its expected strobes (cycle, vector, resulting
// divide/enable) and a negedge monitor pops and compares them as the DUT strobes.
module tb_key_speed_ctrl;
   localparam int DEB = 4;
   localparam int REP = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   key_speed_ctrl_if bus ();

   key_speed_ctrl #(
      .DEBOUNCE_CYCLES (DEB),
      .DIVIDE_INIT     (4'd8),
      .REPEAT_CYCLES   (REP)
   ) dut (
      .clkIn (clk),
      .rst   (rst),
      .bus   (bus)
   );

   typedef struct {
      int         cyc;
      logic [2:0] vec;
      logic [3:0] div;
      logic       en;
   } ev_t;

   ev_t        q[$];
   ev_t        cur;
   bit         post_chk = 1'b0;
   bit         mon_on   = 1'b0;
   int         n_err    = 0;
   int         n_chk    = 0;
   int         cyc      = 0;
   logic [3:0] m_div    = 4'd8;
   logic       m_en     = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Advances the reference model by one strobe and records what the DUT must show.
   task automatic push(input int at, input logic [2:0] vec);
      ev_t e;
      if (vec[0] && !vec[1] && m_div != 4'hF) m_div = m_div + 4'd1;
      if (vec[1] && !vec[0] && m_div != 4'h0) m_div = m_div - 4'd1;
      if (vec[2]) m_en = ~m_en;
      e.cyc = at;
      e.vec = vec;
      e.div = m_div;
      e.en  = m_en;
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         if (post_chk) begin
            chk("divide_after_pulse", bus.divide, cur.div);
            chk("enable_after_pulse", bus.enable, cur.en);
            post_chk = 1'b0;
         end
         if (q.size() > 0 && q[0].cyc < cyc) begin
            chk("missed_pulse_cycle", cyc, q[0].cyc);
            void'(q.pop_front());
         end
         if (bus.key_pulse !== 3'b000) begin
            if (q.size() == 0) begin
               chk("spurious_pulse", bus.key_pulse, 0);
            end else begin
               cur = q.pop_front();
               chk("pulse_vector", bus.key_pulse, cur.vec);
               chk("pulse_cycle", cyc, cur.cyc);
               post_chk = 1'b1;
            end
         end
      end
   end

   // Returns the last cycle at which reset was sampled high.
   task automatic do_reset(output int n);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      n = cyc;
      m_div = 4'd8;
      m_en  = 1'b1;
      chk("reset_divide", bus.divide, 8);
      chk("reset_enable", bus.enable, 1);
      chk("reset_pulse", bus.key_pulse, 0);
   endtask

   task automatic press(input logic [2:0] mask, input int hold);
      int n;
      int p;
      int fall;
      @(negedge clk);
      bus.KEY = bus.KEY & ~mask;
      n = cyc;
      p = n + DEB + 3;
      push(p, mask);
      fall = n + hold + DEB + 2;
`ifdef KEY_SPEED_AUTOREPEAT_EN
      if (mask[1:0] != 2'b00)
         for (int t = p + REP; t <= fall; t += REP) push(t, mask & 3'b011);
`endif
      repeat (hold) @(negedge clk);
      bus.KEY = bus.KEY | mask;
      repeat (DEB + 8) @(negedge clk);
      chk("pulses_pending", q.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int exp_rep;
      bus.KEY = 3'b111;
      do_reset(n);
      mon_on = 1'b1;
      repeat (10) @(negedge clk);
      chk("idle_divide", bus.divide, 8);
      chk("idle_enable", bus.enable, 1);

      press(3'b001, 20);
      chk("single_press_divide", bus.divide, m_div);

      for (int i = 0; i < 10; i++) begin
         bus.KEY[1] = i[0];
         repeat (2) @(negedge clk);
      end
      bus.KEY[1] = 1'b1;
      repeat (12) @(negedge clk);
      chk("bounce_divide", bus.divide, m_div);

      do_reset(n);
      for (int i = 0; i < 9; i++) press(3'b001, 8);
      chk("saturate_high", bus.divide, 15);
      for (int i = 0; i < 17; i++) press(3'b010, 8);
      chk("saturate_low", bus.divide, 0);

      do_reset(n);
      press(3'b011, 8);
      chk("both_keys_divide", bus.divide, 8);
      press(3'b100, 8);
      chk("enable_toggle_off", bus.enable, 0);
      press(3'b100, 8);
      chk("enable_toggle_on", bus.enable, 1);

      // Key 2 pressed, then reset lands mid-debounce while the key stays held.
      @(negedge clk);
      bus.KEY[2] = 1'b0;
      repeat (4) @(negedge clk);
      do_reset(n);
      push(n + DEB + 3, 3'b100);
      repeat (12) @(negedge clk);
      bus.KEY[2] = 1'b1;
      repeat (DEB + 8) @(negedge clk);
      chk("held_through_reset_pending", q.size(), 0);
      chk("held_through_reset_enable", bus.enable, 0);

      do_reset(n);
`ifdef KEY_SPEED_AUTOREPEAT_EN
      exp_rep = 12;
`else
      exp_rep = 9;
`endif
      press(3'b001, 32);
      chk("long_hold_divide", bus.divide, exp_rep);

      repeat (4) @(negedge clk);
      chk("queue_empty", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/key_speed_ctrl.md
KEY_SPEED_CTRL -- requirements
Module: key_speed_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive cycles a synchronized key level must differ from its debounced state before that state flips (range 2..2^20).
REQ-002 The block SHALL have parameter DIVIDE_INIT, default 4'd8, meaning the divide value loaded at reset.
REQ-003 The block SHALL have parameter REPEAT_CYCLES, default 12500000, meaning the auto-repeat period (used only when KEY_SPEED_AUTOREPEAT_EN is defined).
REQ-004 The block SHALL have port clkIn  input  1  meaning the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst  input  1  meaning reset, synchronous, active-high.
REQ-006 The block SHALL have port KEY  input  3  meaning raw asynchronous pushbuttons, active-low: [0] speed up, [1] speed down, [2] enable toggle.
REQ-007 The block SHALL have port divide  output  4  meaning the speed code driven to the downstream divider/LED-HEX stage.
REQ-008 The block SHALL have port enable  output  1  meaning the display-enable level driven to the downstream stage.
REQ-009 The block SHALL have port key_pulse  output  3  meaning a one-cycle registered strobe per key on each debounced press.

Function
REQ-010 Each KEY bit SHALL pass through a two-flop synchronizer and then be inverted, so 1 = pressed.
REQ-011 Each key SHALL have an independent debounce counter that clears on any cycle the synchronized level equals the debounced state and otherwise increments.
REQ-012 The debounced state SHALL flip, and the counter SHALL clear, in the cycle the counter reaches DEBOUNCE_CYCLES-1 while still mismatched, so a flip occurs after exactly DEBOUNCE_CYCLES consecutive mismatched cycles.
REQ-013 A bounce (return to match) before the count completes SHALL clear the counter with no state change.
REQ-014 key_pulse[i] SHALL be high for exactly one cycle, in the cycle after debounced key i goes 0->1; a release SHALL produce no pulse.
REQ-015 divide SHALL increment by 1 in the cycle after key_pulse[0], saturating at 15 (no wrap).
REQ-016 divide SHALL decrement by 1 in the cycle after key_pulse[1], saturating at 0 (no wrap).
REQ-017 If key_pulse[0] and key_pulse[1] are high in the same cycle, divide SHALL NOT change.
REQ-018 enable SHALL toggle in the cycle after key_pulse[2], independently of divide updates in the same cycle.
REQ-019 Total latency from a clean KEY press edge to the divide/enable update SHALL be 2 (sync) + DEBOUNCE_CYCLES + 1 (pulse) + 1 (update) cycles.

Reset
REQ-020 While rst is high at a clkIn edge, the block SHALL set: divide=DIVIDE_INIT, enable=1, key_pulse=0, all debounced states=0 (released), all counters=0, synchronizer flops=0 (pressed-free).
REQ-021 A key held through reset deassertion SHALL be debounced afresh and SHALL produce exactly one press pulse after DEBOUNCE_CYCLES.
REQ-022 Reset asserted mid-debounce or mid-repeat SHALL abandon the count with no pulse.

Configuration
REQ-023 When macro KEY_SPEED_AUTOREPEAT_EN is defined, a debounced-held key 0 or 1 SHALL emit an additional key_pulse every REPEAT_CYCLES after its press pulse until release; key 2 SHALL never repeat.
REQ-024 When KEY_SPEED_AUTOREPEAT_EN is undefined, no repeat counter SHALL be built and each press SHALL produce exactly one pulse.

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8 in bench)
REQ-025 Reset then idle -> divide=8, enable=1, key_pulse=0.
REQ-026 KEY[0] low held 20 cycles -> one key_pulse[0] at cycle 7 after the edge, divide=9 at cycle 8; no pulse on release.
REQ-027 KEY[1] toggling every 2 cycles for 20 cycles then returning high -> no pulse, divide unchanged.
REQ-028 Nine clean KEY[0] presses from divide=8 -> divide ends at 15; 17 KEY[1] presses -> divide ends at 0.
REQ-029 KEY[0] and KEY[1] pressed on the same cycle -> both pulses in the same cycle, divide unchanged; KEY[2] press -> enable 1->0, second press -> 0->1.
REQ-030 With KEY_SPEED_AUTOREPEAT_EN, KEY[0] held 30 cycles past its press pulse from divide=8 -> pulses at +0, +8, +16, +24, divide=12; without the macro -> divide=9.
